// File: rtl/play_scheduler.sv
// Tone-path arbiter between user keys and the auto-play engine, with muted mode changes
// and LEARN-mode scoring of user presses against the engine's current note.
module play_scheduler #(
    parameter int NUM_KEYS    = 7,
    parameter int MUTE_CYCLES = 16,
    parameter int SCORE_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode_sel,
    input  logic [2:0]          song_sel,
    input  logic [NUM_KEYS-1:0] user_keys,
    input  logic [3:0]          eng_key,
    input  logic                eng_key_on,
    output logic                eng_rst,
    output logic [2:0]          eng_song,
    output logic [3:0]          tone_key,
    output logic                tone_on,
    output logic [3:0]          led_expect,
    output logic [SCORE_W-1:0]  score,
    output logic [2:0]          mode_state
);

    localparam int              CNT_W    = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);

    // Codes of the four playing states equal the mode_sel value that selects them.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FREE  = 3'd1,
        S_AUTO  = 3'd2,
        S_LEARN = 3'd3,
        S_MUTE  = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_target, w_target_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]         r_prev_key;
    logic               r_prev_on;
    logic               r_credited, w_credited_nxt;
    logic [3:0]         w_note;
    logic               w_entry, w_learn_stay, w_rearm, w_hit;
    logic [3:0]         w_tone_key_nxt, w_led_nxt;
    logic               w_tone_on_nxt, w_eng_rst_nxt;
    logic [2:0]         w_eng_song_nxt;
    logic [SCORE_W-1:0] w_score_nxt;

    // Lowest-index pressed key wins.
    always_comb begin
        w_note = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (user_keys[k]) w_note = 4'(k + 1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        if (r_state == S_MUTE) begin
            if (mode_sel != r_target) begin
                w_target_nxt = mode_sel;
                w_cnt_nxt    = CNT_LOAD;
            end else if (r_cnt == '0) begin
                w_state_nxt = state_t'({1'b0, r_target});
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end else if (mode_sel != r_state[1:0]) begin
            w_state_nxt  = S_MUTE;
            w_target_nxt = mode_sel;
            w_cnt_nxt    = CNT_LOAD;
        end
    end

    assign w_entry      = (r_state == S_MUTE) && (w_state_nxt != S_MUTE);
    assign w_learn_stay = (r_state == S_LEARN) && (w_state_nxt == S_LEARN);
    // A new note starts when the engine changes pitch or re-strikes the same pitch.
    assign w_rearm      = (eng_key != r_prev_key) || (eng_key_on && !r_prev_on);
    assign w_hit        = w_learn_stay && (w_note != 4'd0) && (w_note == eng_key) &&
                          eng_key_on && (w_rearm || !r_credited);

    // Outputs are computed for the state being entered so they register with it.
    always_comb begin
        w_tone_key_nxt = '0;
        w_tone_on_nxt  = 1'b0;
        w_eng_rst_nxt  = 1'b1;
        w_led_nxt      = '0;
        w_eng_song_nxt = eng_song;
        w_score_nxt    = score;
        w_credited_nxt = w_rearm ? w_hit : (r_credited | w_hit);
        case (w_state_nxt)
            S_FREE: begin
                w_tone_key_nxt = w_note;
                w_tone_on_nxt  = (w_note != 4'd0);
            end
            S_AUTO: begin
                w_tone_key_nxt = eng_key;
                w_tone_on_nxt  = eng_key_on;
                w_eng_rst_nxt  = 1'b0;
                if (w_entry) w_eng_song_nxt = song_sel;
            end
            S_LEARN: begin
                w_tone_key_nxt = w_note;
                w_tone_on_nxt  = (w_note != 4'd0);
                w_eng_rst_nxt  = 1'b0;
                w_led_nxt      = eng_key;
                if (w_entry) begin
                    w_eng_song_nxt = song_sel;
                    w_score_nxt    = '0;
                    w_credited_nxt = 1'b0;
                end else if (w_hit && (score != '1)) begin
                    w_score_nxt = score + SCORE_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_cnt      <= '0;
            r_prev_key <= '0;
            r_prev_on  <= 1'b0;
            r_credited <= 1'b0;
            eng_rst    <= 1'b1;
            eng_song   <= '0;
            tone_key   <= '0;
            tone_on    <= 1'b0;
            led_expect <= '0;
            score      <= '0;
            mode_state <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_cnt      <= w_cnt_nxt;
            r_prev_key <= eng_key;
            r_prev_on  <= eng_key_on;
            r_credited <= w_credited_nxt;
            eng_rst    <= w_eng_rst_nxt;
            eng_song   <= w_eng_song_nxt;
            tone_key   <= w_tone_key_nxt;
            tone_on    <= w_tone_on_nxt;
            led_expect <= w_led_nxt;
            score      <= w_score_nxt;
            mode_state <= w_state_nxt;
        end
    end

endmodule

// File: tb/tb_play_scheduler.sv
// Directed bench for play_scheduler: a default instance plus a SCORE_W=2 instance on the
// same inputs for the score saturation case.
module tb_play_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode_sel;
    logic [2:0] song_sel;
    logic [6:0] user_keys;
    logic [3:0] eng_key;
    logic       eng_key_on;

    logic       eng_rst, tone_on;
    logic [2:0] eng_song, mode_state;
    logic [3:0] tone_key, led_expect;
    logic [7:0] score;

    logic       eng_rst2, tone_on2;
    logic [2:0] eng_song2, mode_state2;
    logic [3:0] tone_key2, led_expect2;
    logic [1:0] score2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    play_scheduler dut (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .song_sel(song_sel),
        .user_keys(user_keys), .eng_key(eng_key), .eng_key_on(eng_key_on),
        .eng_rst(eng_rst), .eng_song(eng_song), .tone_key(tone_key), .tone_on(tone_on),
        .led_expect(led_expect), .score(score), .mode_state(mode_state)
    );

    play_scheduler #(.NUM_KEYS(7), .MUTE_CYCLES(16), .SCORE_W(2)) dut_sat (
        .clk(clk), .rst(rst), .mode_sel(mode_sel), .song_sel(song_sel),
        .user_keys(user_keys), .eng_key(eng_key), .eng_key_on(eng_key_on),
        .eng_rst(eng_rst2), .eng_song(eng_song2), .tone_key(tone_key2), .tone_on(tone_on2),
        .led_expect(led_expect2), .score(score2), .mode_state(mode_state2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mode_sel = 2'd0; song_sel = 3'd0; user_keys = '0;
        eng_key = 4'd0; eng_key_on = 1'b0;
        step(2);
        checks++; if (mode_state !== 3'd0) begin errors++; $display("FAIL reset_mode_state: got %0d expected 0", mode_state); end
        checks++; if (eng_rst !== 1'b1) begin errors++; $display("FAIL reset_eng_rst: got %0b expected 1", eng_rst); end
        checks++; if (tone_on !== 1'b0 || tone_key !== 4'd0) begin errors++; $display("FAIL reset_tone: got on=%0b key=%0d expected 0/0", tone_on, tone_key); end
        checks++; if (eng_song !== 3'd0 || led_expect !== 4'd0 || score !== 8'd0) begin errors++; $display("FAIL reset_misc: got song=%0d led=%0d score=%0d expected 0/0/0", eng_song, led_expect, score); end
        rst = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (mode_state !== 3'd0 || tone_on !== 1'b0 || eng_rst !== 1'b1) begin
                errors++; $display("FAIL idle_hold cycle %0d: got state=%0d on=%0b eng_rst=%0b expected 0/0/1", i, mode_state, tone_on, eng_rst);
            end
        end
    endtask

    task automatic test_free();
        user_keys = 7'b0010100;
        mode_sel  = 2'd1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            checks++;
            if (tone_on !== 1'b0 || mode_state !== 3'd4) begin
                errors++; $display("FAIL free_mute cycle %0d: got on=%0b state=%0d expected 0/4", i, tone_on, mode_state);
            end
        end
        step(1);
        checks++; if (mode_state !== 3'd1 || eng_rst !== 1'b1) begin errors++; $display("FAIL free_entry: got state=%0d eng_rst=%0b expected 1/1", mode_state, eng_rst); end
        checks++; if (tone_key !== 4'd3 || tone_on !== 1'b1) begin errors++; $display("FAIL free_tone: got key=%0d on=%0b expected 3/1", tone_key, tone_on); end
        user_keys = '0;
        checks++; if (tone_on !== 1'b1) begin errors++; $display("FAIL free_latency: got on=%0b expected 1 before edge", tone_on); end
        step(1);
        checks++; if (tone_on !== 1'b0 || tone_key !== 4'd0) begin errors++; $display("FAIL free_release: got on=%0b key=%0d expected 0/0", tone_on, tone_key); end
        user_keys = 7'b1000000;
        step(1);
        checks++; if (tone_key !== 4'd7 || tone_on !== 1'b1) begin errors++; $display("FAIL free_top_key: got key=%0d on=%0b expected 7/1", tone_key, tone_on); end
        user_keys = 7'b1111111;
        step(1);
        checks++; if (tone_key !== 4'd1) begin errors++; $display("FAIL free_all_keys: got key=%0d expected 1", tone_key); end
    endtask

    task automatic test_auto();
        user_keys = 7'b0000001;
        mode_sel = 2'd2; song_sel = 3'd5; eng_key = 4'd0; eng_key_on = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            checks++;
            if (mode_state !== 3'd4 || tone_on !== 1'b0 || eng_rst !== 1'b1) begin
                errors++; $display("FAIL auto_mute cycle %0d: got state=%0d on=%0b eng_rst=%0b expected 4/0/1", i, mode_state, tone_on, eng_rst);
            end
        end
        step(1);
        checks++; if (mode_state !== 3'd2 || eng_rst !== 1'b0 || eng_song !== 3'd5) begin errors++; $display("FAIL auto_entry: got state=%0d eng_rst=%0b song=%0d expected 2/0/5", mode_state, eng_rst, eng_song); end
        checks++; if (tone_on !== 1'b0 || tone_key !== 4'd0) begin errors++; $display("FAIL auto_keys_ignored: got on=%0b key=%0d expected 0/0", tone_on, tone_key); end
        eng_key = 4'd9; eng_key_on = 1'b1;
        checks++; if (tone_key !== 4'd0) begin errors++; $display("FAIL auto_latency: got key=%0d expected 0 before edge", tone_key); end
        step(1);
        checks++; if (tone_key !== 4'd9 || tone_on !== 1'b1) begin errors++; $display("FAIL auto_follow: got key=%0d on=%0b expected 9/1", tone_key, tone_on); end
        eng_key = 4'd12;
        step(1);
        checks++; if (tone_key !== 4'd12) begin errors++; $display("FAIL auto_follow2: got key=%0d expected 12", tone_key); end
        song_sel = 3'd2;
        step(3);
        checks++; if (eng_song !== 3'd5 || eng_rst !== 1'b0) begin errors++; $display("FAIL auto_song_hold: got song=%0d eng_rst=%0b expected 5/0", eng_song, eng_rst); end
    endtask

    task automatic test_reset_mid();
        #3;
        rst = 1'b0;
        #1;
        checks++; if (tone_on !== 1'b0 || tone_key !== 4'd0) begin errors++; $display("FAIL rstmid_tone: got on=%0b key=%0d expected 0/0", tone_on, tone_key); end
        checks++; if (eng_rst !== 1'b1 || eng_song !== 3'd0 || mode_state !== 3'd0) begin errors++; $display("FAIL rstmid_state: got eng_rst=%0b song=%0d state=%0d expected 1/0/0", eng_rst, eng_song, mode_state); end
        mode_sel = 2'd0; user_keys = '0; eng_key = 4'd0; eng_key_on = 1'b0;
        step(1);
        checks++; if (mode_state !== 3'd0 || eng_rst !== 1'b1) begin errors++; $display("FAIL rstmid_held: got state=%0d eng_rst=%0b expected 0/1", mode_state, eng_rst); end
        rst = 1'b1;
        step(3);
        checks++; if (mode_state !== 3'd0 || eng_rst !== 1'b1 || tone_on !== 1'b0) begin errors++; $display("FAIL rstmid_release: got state=%0d eng_rst=%0b on=%0b expected 0/1/0", mode_state, eng_rst, tone_on); end
    endtask

    task automatic test_retarget();
        song_sel = 3'd3;
        mode_sel = 2'd2;
        step(1);
        checks++; if (mode_state !== 3'd4) begin errors++; $display("FAIL retarget_mute: got state=%0d expected 4", mode_state); end
        step(4);
        mode_sel = 2'd1;
        step(6);
        checks++; if (mode_state !== 3'd4) begin errors++; $display("FAIL retarget_mid: got state=%0d expected 4", mode_state); end
        mode_sel = 2'd3;
        for (int i = 0; i < 16; i++) begin
            step(1);
            checks++;
            if (mode_state !== 3'd4 || eng_rst !== 1'b1) begin
                errors++; $display("FAIL retarget_hold cycle %0d: got state=%0d eng_rst=%0b expected 4/1", i, mode_state, eng_rst);
            end
        end
        step(1);
        checks++; if (mode_state !== 3'd3 || eng_rst !== 1'b0 || eng_song !== 3'd3) begin errors++; $display("FAIL retarget_entry: got state=%0d eng_rst=%0b song=%0d expected 3/0/3", mode_state, eng_rst, eng_song); end
        checks++; if (score !== 8'd0 || score2 !== 2'd0) begin errors++; $display("FAIL retarget_score: got %0d/%0d expected 0/0", score, score2); end
    endtask

    task automatic test_learn();
        eng_key = 4'd4; eng_key_on = 1'b1; user_keys = 7'b0001000;
        step(1);
        checks++; if (score !== 8'd1 || score2 !== 2'd1) begin errors++; $display("FAIL learn_hit1: got %0d/%0d expected 1/1", score, score2); end
        checks++; if (led_expect !== 4'd4 || tone_key !== 4'd4 || tone_on !== 1'b1) begin errors++; $display("FAIL learn_outputs: got led=%0d key=%0d on=%0b expected 4/4/1", led_expect, tone_key, tone_on); end
        step(2);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL learn_hold_once: got %0d expected 1", score); end
        eng_key_on = 1'b0;
        step(1);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL learn_gap: got %0d expected 1", score); end
        eng_key_on = 1'b1;
        step(1);
        checks++; if (score !== 8'd2 || score2 !== 2'd2) begin errors++; $display("FAIL learn_hit2: got %0d/%0d expected 2/2", score, score2); end
        eng_key = 4'd6;
        step(2);
        checks++; if (score !== 8'd2 || led_expect !== 4'd6) begin errors++; $display("FAIL learn_miss: got score=%0d led=%0d expected 2/6", score, led_expect); end
        eng_key = 4'd4;
        step(1);
        checks++; if (score !== 8'd3 || score2 !== 2'd3) begin errors++; $display("FAIL learn_hit3: got %0d/%0d expected 3/3", score, score2); end
        eng_key_on = 1'b0;
        step(1);
        eng_key_on = 1'b1;
        step(1);
        checks++; if (score !== 8'd4) begin errors++; $display("FAIL learn_hit4: got %0d expected 4", score); end
        checks++; if (score2 !== 2'd3) begin errors++; $display("FAIL learn_saturate: got %0d expected 3", score2); end
        mode_sel = 2'd0;
        step(17);
        checks++; if (mode_state !== 3'd0 || score !== 8'd4 || led_expect !== 4'd0 || eng_rst !== 1'b1) begin errors++; $display("FAIL learn_exit: got state=%0d score=%0d led=%0d eng_rst=%0b expected 0/4/0/1", mode_state, score, led_expect, eng_rst); end
        eng_key_on = 1'b0; user_keys = '0;
        mode_sel = 2'd3;
        step(17);
        checks++; if (mode_state !== 3'd3 || score !== 8'd0 || score2 !== 2'd0) begin errors++; $display("FAIL learn_reentry_clear: got state=%0d score=%0d/%0d expected 3/0/0", mode_state, score, score2); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_free();
        test_auto();
        test_reset_mid();
        test_retarget();
        test_learn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
